// File: rtl/comb_sweep_ctrl.sv
// Exhaustive-sweep sequencer: steps dut_in through every vector, waits SETTLE
// cycles per vector, then records dut_y into a truth table and a minterm count.
module comb_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dut_y,
  output logic [WIDTH-1:0]      dut_in,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   truth_table,
  output logic [WIDTH:0]        ones_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] LAST_VEC   = {WIDTH{1'b1}};
  localparam logic [7:0]       CNT_RELOAD = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  // With no settle time the sequencer skips SETTLE and samples every cycle.
  localparam state_t           AFTER_LOAD = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]      dut_in_q, dut_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2**WIDTH-1:0]   tt_q, tt_d;
  logic [WIDTH:0]        ones_q, ones_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tt_q     <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tt_q     <= tt_d;
      ones_q   <= ones_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tt_d     = tt_q;
    ones_d   = ones_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dut_in_d = '0;
          tt_d     = '0;
          ones_d   = '0;
          busy_d   = 1'b1;
          cnt_d    = CNT_RELOAD;
          state_d  = AFTER_LOAD;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
        end else if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_SAMPLE: begin
        // Abort wins over the capture, so the current vector is left unrecorded.
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
        end else begin
          tt_d[dut_in_q] = dut_y;
          ones_d         = ones_q + {{WIDTH{1'b0}}, dut_y};
          if (dut_in_q == LAST_VEC) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            dut_in_d = dut_in_q + 1'b1;
            cnt_d    = CNT_RELOAD;
            state_d  = AFTER_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dut_in      = dut_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign ones_count  = ones_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed bench for comb_sweep_ctrl: default instance (SETTLE=2) and a
// zero-settle instance, each with dut_y looped back through a selectable function.
module tb_comb_sweep_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start_a, abort_a, dut_y_a, busy_a, done_a;
  logic [3:0]  dut_in_a;
  logic [15:0] tt_a;
  logic [4:0]  ones_a;
  int          mode_a;

  logic        start_b, abort_b, dut_y_b, busy_b, done_b;
  logic [3:0]  dut_in_b;
  logic [15:0] tt_b;
  logic [4:0]  ones_b;
  int          mode_b;

  int n_checks;
  int n_fail;

  // mode 0: A&D, 1: tied 1, 2: tied 0, 3: parity
  function automatic logic fn(input int mode, input logic [3:0] v);
    case (mode)
      0:       return v[0] & v[3];
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ^v;
    endcase
  endfunction

  assign dut_y_a = fn(mode_a, dut_in_a);
  assign dut_y_b = fn(mode_b, dut_in_b);

  comb_sweep_ctrl #(.WIDTH(4), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_y(dut_y_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
    .truth_table(tt_a), .ones_count(ones_a)
  );

  comb_sweep_ctrl #(.WIDTH(4), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_y(dut_y_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
    .truth_table(tt_b), .ones_count(ones_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse in cycle 0; watches cycles 1..50. ign1/ign2 re-assert start.
  task automatic sweep_a(input string tag, input int mode, input int ign1, input int ign2,
                         input logic [15:0] exp_tt, input logic [4:0] exp_ones);
    int done_cycle, done_cnt, busy_err, din_err;
    logic [3:0] exp_din;
    done_cycle = -1; done_cnt = 0; busy_err = 0; din_err = 0;
    mode_a  = mode;
    start_a = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      start_a = (c == ign1) || (c == ign2);
      if (done_a) begin done_cnt++; done_cycle = c; end
      if (busy_a !== (c <= 48)) busy_err++;
      exp_din = (c <= 48) ? 4'((c - 1) / 3) : 4'd15;
      if (dut_in_a !== exp_din) din_err++;
      if (c < 50) step();
    end
    start_a = 1'b0;
    check({tag, " done_cycle"}, 64'(done_cycle), 64'd49);
    check({tag, " done_cnt"},   64'(done_cnt),   64'd1);
    check({tag, " busy_err"},   64'(busy_err),   64'd0);
    check({tag, " din_err"},    64'(din_err),    64'd0);
    check({tag, " tt"},         64'(tt_a),       64'(exp_tt));
    check({tag, " ones"},       64'(ones_a),     64'(exp_ones));
  endtask

  task automatic wait_done_a(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done_a) seen = 1'b1;
      else step();
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic abort_test(input string tag, input int abort_cycle);
    int done_cnt;
    done_cnt = 0;
    mode_a  = 1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c < abort_cycle; c++) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check({tag, " busy"},   64'(busy_a),   64'd0);
    check({tag, " dut_in"}, 64'(dut_in_a), 64'd0);
    for (int i = 0; i < 60; i++) begin
      if (done_a) done_cnt++;
      step();
    end
    check({tag, " no_done"}, 64'(done_cnt), 64'd0);
    check({tag, " tt"},      64'(tt_a),     64'h0007);
    check({tag, " ones"},    64'(ones_a),   64'd3);
  endtask

  initial begin
    int done_cycle, din_err, busy_err;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 3;
    repeat (3) step();
    check("reset dut_in", 64'(dut_in_a), 64'd0);
    check("reset busy",   64'(busy_a),   64'd0);
    check("reset done",   64'(done_a),   64'd0);
    check("reset tt",     64'(tt_a),     64'd0);
    check("reset ones",   64'(ones_a),   64'd0);
    #2 rst_n = 1'b1;
    step();

    sweep_a("and",  0, -1, -1, 16'hAA00, 5'd4);
    sweep_a("one",  1, -1, -1, 16'hFFFF, 5'd16);
    sweep_a("zero", 2, -1, -1, 16'h0000, 5'd0);

    // Ignored starts in cycles 5 and 30, then restart from cycle 50.
    sweep_a("ign", 0, 5, 30, 16'hAA00, 5'd4);
    mode_a  = 1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("restart tt",     64'(tt_a),     64'd0);
    check("restart ones",   64'(ones_a),   64'd0);
    check("restart busy",   64'(busy_a),   64'd1);
    check("restart dut_in", 64'(dut_in_a), 64'd0);
    wait_done_a("restart");
    check("restart tt_end",   64'(tt_a),   64'hFFFF);
    check("restart ones_end", 64'(ones_a), 64'd16);
    step();

    abort_test("abort_settle", 10);
    abort_test("abort_sample", 12);

    // start and abort together in IDLE: start wins.
    mode_a  = 3;
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    check("start_abort busy", 64'(busy_a), 64'd1);
    wait_done_a("start_abort");
    check("start_abort tt",   64'(tt_a),   64'h6996);
    check("start_abort ones", 64'(ones_a), 64'd8);
    step();

    // Asynchronous reset mid-sweep.
    mode_a  = 1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c < 20; c++) step();
    check("pre_rst tt", 64'(tt_a), 64'h003F);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst busy",   64'(busy_a),   64'd0);
    check("async_rst dut_in", 64'(dut_in_a), 64'd0);
    check("async_rst tt",     64'(tt_a),     64'd0);
    check("async_rst ones",   64'(ones_a),   64'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    sweep_a("post_rst", 0, -1, -1, 16'hAA00, 5'd4);

    // Zero-settle instance with parity function.
    done_cycle = -1; din_err = 0; busy_err = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (done_b) done_cycle = c;
      if (busy_b !== (c <= 16)) busy_err++;
      if (dut_in_b !== ((c <= 16) ? 4'(c - 1) : 4'd15)) din_err++;
      step();
    end
    check("s0 done_cycle", 64'(done_cycle), 64'd17);
    check("s0 busy_err",   64'(busy_err),   64'd0);
    check("s0 din_err",    64'(din_err),    64'd0);
    check("s0 tt",         64'(tt_b),       64'h6996);
    check("s0 ones",       64'(ones_b),     64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
